// File: rtl/detector_arbiter.sv
// Round-robin owner of one shared 2-bit sequence detector; the detector is reset (FLUSH) between owners.
// Optional macro ARB_PREEMPT_EN bounds a grant to MAX_HOLD RUN cycles while others are waiting.
module detector_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic [N-1:0] bit_in,
  input  logic [1:0]   det_state,
  output logic         det_in,
  output logic         det_reset,
  output logic [N-1:0] grant,
  output logic         match,
  output logic         busy
);

  localparam int OW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] FLUSH = 2'b01;
  localparam logic [1:0] RUN   = 2'b10;

  logic [1:0]    state;
  logic [OW-1:0] owner;
  logic [OW-1:0] last_owner;
  logic [OW-1:0] base;
  logic [OW-1:0] idx;
  logic [OW-1:0] pick;
  logic [N-1:0]  own_oh;
  logic [N-1:0]  cand;
  logic          found;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_inc;

  assign own_oh   = {{(N-1){1'b0}}, 1'b1} << owner;
  assign hold_inc = (hold_cnt == HW'(MAX_HOLD)) ? hold_cnt : hold_cnt + 1'b1;

  // While running, the search starts after the current owner and never re-picks it.
  always_comb begin
    base  = (state == RUN) ? owner : last_owner;
    cand  = (state == RUN) ? (req & ~own_oh) : req;
    pick  = base;
    idx   = base;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = OW'((int'(base) + i) % N);
      if (!found && cand[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= OW'(N - 1);
      hold_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            owner    <= pick;
            state    <= FLUSH;
            hold_cnt <= '0;
          end
        end
        FLUSH: state <= RUN;
        RUN: begin
          if (!req[owner]) begin
            last_owner <= owner;
            if (|cand) begin
              owner    <= pick;
              state    <= FLUSH;
              hold_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            hold_cnt <= hold_inc;
`ifdef ARB_PREEMPT_EN
            // hold_inc counts the RUN cycle now ending, so the grant lasts exactly MAX_HOLD cycles.
            if ((hold_inc == HW'(MAX_HOLD)) && (|cand)) begin
              last_owner <= owner;
              owner      <= pick;
              state      <= FLUSH;
              hold_cnt   <= '0;
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign grant     = busy ? own_oh : '0;
  assign det_reset = (state != RUN);
  assign det_in    = (state == RUN) && bit_in[owner];
  assign match     = (state == RUN) && (det_state == 2'b10);

endmodule

// File: tb/tb_detector_arbiter.sv
// Directed bench for detector_arbiter (N=4, MAX_HOLD=8) with a small model of the shared 2-bit detector.
module tb_detector_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] bit_in = 4'b0000;
  logic [1:0] det_state = 2'b00;
  logic       det_in;
  logic       det_reset;
  logic [3:0] grant;
  logic       match;
  logic       busy;

  int n_vec  = 0;
  int n_miss = 0;

  detector_arbiter #(.N(4), .MAX_HOLD(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .bit_in    (bit_in),
    .det_state (det_state),
    .det_in    (det_in),
    .det_reset (det_reset),
    .grant     (grant),
    .match     (match),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Shared detector: counts consecutive ones, reaching 2'b10 after two.
  always @(posedge clk) begin
    if (det_reset)      det_state <= 2'b00;
    else if (!det_in)   det_state <= 2'b00;
    else if (det_state == 2'b00) det_state <= 2'b01;
    else                det_state <= 2'b10;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Asynchronous reset before any clock edge
    #3 reset = 1'b1;
    #1;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_det_reset", 32'(det_reset), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_match", 32'(match), 32'h0);
    check("rst_det_in", 32'(det_in), 32'h0);
    tick();
    reset = 1'b0;

    // Single requester, detection of two ones
    req = 4'b0001;
    check("idle_grant", 32'(grant), 32'h0);
    tick();
    check("flush_grant", 32'(grant), 32'h1);
    check("flush_det_reset", 32'(det_reset), 32'h1);
    check("flush_busy", 32'(busy), 32'h1);
    tick();
    check("run_det_reset", 32'(det_reset), 32'h0);
    check("run_grant", 32'(grant), 32'h1);
    bit_in = 4'b0001;
    #1;
    check("run_det_in_1", 32'(det_in), 32'h1);
    check("run_match_pre", 32'(match), 32'h0);
    tick();
    tick();
    check("det_state_10", 32'(det_state), 32'h2);
    check("match_hi", 32'(match), 32'h1);
    bit_in = 4'b0000;
    #1;
    check("run_det_in_0", 32'(det_in), 32'h0);
    tick();
    check("match_lo", 32'(match), 32'h0);

    // Owner drops with nobody else waiting
    req = 4'b0000;
    tick();
    check("drop_idle_grant", 32'(grant), 32'h0);
    check("drop_idle_busy", 32'(busy), 32'h0);
    check("drop_idle_det_reset", 32'(det_reset), 32'h1);

    // Two requesters after reset, handover through FLUSH
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 4'b0101;
    tick();
    check("rr0_flush_grant", 32'(grant), 32'h1);
    tick();
    tick();
    check("rr0_run_grant", 32'(grant), 32'h1);
    req = 4'b0100;
    tick();
    check("hand_flush_grant", 32'(grant), 32'h4);
    check("hand_flush_det_reset", 32'(det_reset), 32'h1);
    check("hand_flush_match", 32'(match), 32'h0);
    req = 4'b0110;
    tick();
    check("hand_run_grant", 32'(grant), 32'h4);
    check("hand_run_det_reset", 32'(det_reset), 32'h0);
    bit_in = 4'b0100;
    #1;
    check("owner2_det_in_1", 32'(det_in), 32'h1);
    bit_in = 4'b0001;
    #1;
    check("owner2_det_in_0", 32'(det_in), 32'h0);
    bit_in = 4'b0000;

    // Reset mid-RUN with owner 2
    #2 reset = 1'b1;
    #1;
    check("midrun_rst_grant", 32'(grant), 32'h0);
    check("midrun_rst_busy", 32'(busy), 32'h0);
    check("midrun_rst_det_reset", 32'(det_reset), 32'h1);
    check("midrun_rst_match", 32'(match), 32'h0);
    tick();
    reset = 1'b0;
    req = 4'b1111;
    tick();
    check("post_rst_grant", 32'(grant), 32'h1);
    tick();
    check("post_rst_run_grant", 32'(grant), 32'h1);

    // Sustained contention between requesters 0 and 1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 4'b0011;
    tick();
    tick();
    for (int k = 0; k < 8; k++) begin
      check($sformatf("hold_grant_%0d", k), 32'(grant), 32'h1);
      tick();
    end
`ifdef ARB_PREEMPT_EN
    check("preempt_flush_grant", 32'(grant), 32'h2);
    check("preempt_flush_det_reset", 32'(det_reset), 32'h1);
    tick();
    check("preempt_run_grant", 32'(grant), 32'h2);
`else
    check("nopreempt_grant_a", 32'(grant), 32'h1);
    repeat (20) tick();
    check("nopreempt_grant_b", 32'(grant), 32'h1);
    check("nopreempt_det_reset", 32'(det_reset), 32'h0);
`endif
    req = 4'b0000;
    repeat (3) tick();
    check("contend_idle_grant", 32'(grant), 32'h0);

    // Wrap-around of the round-robin search
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 4'b1000;
    tick();
    check("wrap_first_grant", 32'(grant), 32'h8);
    tick();
    req = 4'b1001;
    tick();
    check("wrap_keep_grant", 32'(grant), 32'h8);
    req = 4'b0001;
    tick();
    check("wrap_flush_grant", 32'(grant), 32'h1);
    req = 4'b0000;
    repeat (3) tick();
    check("wrap_idle_busy", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
